milano_mdu: RTL and testbench
=============================

Name: milano_mdu

Overview:
- Parametrised multi-cycle multiply/divide unit for the Milano execute stage.
- Implements all md_opt_e operations (MUL, MULH, MULSU, MULU, DIV, DIVU, REM, REMU) for an XLEN-wide datapath.
- Uses a valid/ready handshake on both sides and accepts a pipeline flush.
- Generalises the single RV32M decode with:
  - selectable multiplier architecture (single-cycle or iterative);
  - configurable divider radix;
  - early-out for divide-by-zero and signed overflow.

Parameters:
- XLEN, 32, operand/result width; legal values 32 or 64.
- MUL_FAST, 1, multiplier architecture. 1 = single-cycle full product. 0 = iterative shift-add, 1 bit per cycle.
- DIV_BITS, 1, quotient bits retired per divider cycle; legal values 1, 2, 4. XLEN % DIV_BITS == 0.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  synchronous reset, active low.
- valid_i  in  1  operation request.
- ready_o  out  1  unit can accept a request (state IDLE).
- md_op_i  in  4  operation, milano_pkg::md_opt_e.
- op_a_i  in  XLEN  rs1 operand.
- op_b_i  in  XLEN  rs2 operand.
- flush_i  in  1  abort the in-flight operation (branch/exception).
- valid_o  out  1  result_o is valid.
- ready_i  in  1  consumer takes the result.
- result_o  out  XLEN  result.
- busy_o  out  1  state != IDLE.

Behaviour:
- Reset (rst_ni==0 at a clock edge):
  - state=IDLE; ready_o=1; valid_o=0; busy_o=0; result_o=0.
  - All internal registers are cleared.
  - Reset mid-operation discards the operation; no result is produced.
- Accept: valid_i && ready_o at an edge latches op/operands. Acceptance cycle is called t.
  - md_op_i==MD_OP_NONE with valid_i is ignored: not accepted, ready_o stays 1.
- States: IDLE, MUL, DIV, FIX, DONE.
  - IDLE → MUL (mul ops), DIV (div/rem ops), or DONE (early-out).
  - MUL → DONE after 1 cycle (MUL_FAST=1) or XLEN cycles (MUL_FAST=0).
  - DIV → FIX after XLEN/DIV_BITS cycles.
  - FIX → DONE after 1 cycle; FIX applies sign correction.
  - DONE → IDLE on ready_i.
- Latency, from t to first cycle valid_o=1:
  - mul: 1 (fast) or XLEN (iterative);
  - div/rem: XLEN/DIV_BITS + 1;
  - early-out: 1.
- Output hold: valid_o and result_o are stable in DONE until ready_i=1.
  - ready_i sampled at the DONE edge returns the unit to IDLE; ready_o=1 the next cycle.
  - There is no accept in the same cycle as the result handoff.
- Multiply:
  - Product is 2*XLEN bits. Operands are sign-extended per op: MULH s*s, MULSU s*u, MULU u*u.
  - MUL returns the low XLEN bits; the MULH variants return the high XLEN bits.
  - The iterative multiplier operates on the magnitude of signed operands; the sign is restored in the final cycle. No extra cycle is added.
- Divide: restoring divider on magnitudes, DIV_BITS quotient bits per cycle. FIX negates per RISC-V rules:
  - quotient negative iff signs differ;
  - remainder takes the dividend's sign.
- Early-out, checked in IDLE at accept, result is registered:
  - op_b==0: DIV/DIVU → all ones; REM/REMU → op_a.
  - Signed op_a==MIN_INT and op_b==-1: DIV → MIN_INT; REM → 0.
- Flush: flush_i=1 at any edge with state != IDLE → IDLE next cycle, valid_o=0, result dropped.
  - flush_i together with an accept in IDLE: the request is not accepted.
  - flush_i in DONE drops the pending result even if ready_i=1 in the same cycle.
- Reset has priority over flush; flush has priority over handshake.

Decomposition:
- md_opt_e is already in milano_pkg.
- Add to milano_pkg:
  - typedef enum mdu_state_e {MDU_IDLE, MDU_MUL, MDU_DIV, MDU_FIX, MDU_DONE};
  - helper function md_is_signed_a/b(md_opt_e).
- One sub-module: milano_div_step, the combinational DIV_BITS-bit restoring step (partial remainder, divisor → next remainder, quotient bits). It is instantiated once; the FSM, multiplier and sign logic stay in milano_mdu.

Test Plan:
- XLEN=32, MUL_FAST=1: MULH 0x80000000*0x80000000 → valid_o at t+1, result 0x40000000. MULU 0xFFFFFFFF*0xFFFFFFFF then MUL → 0xFFFFFFFE / 0x00000001 (high/low).
- DIV_BITS=1: DIV -7/2 → -3 (0xFFFFFFFD), valid_o at t+33. REM -7/2 → 0xFFFFFFFF. DIVU 100/7 → 14. REMU → 2. DIV_BITS=4: same values, valid_o at t+9.
- Divide by zero: DIVU 5/0 → 0xFFFFFFFF. REM 5/0 → 5. Overflow: DIV 0x80000000/-1 → 0x80000000; REM → 0. All with valid_o at t+1.
- Backpressure: hold ready_i=0 for 5 cycles after valid_o → result_o and valid_o stable, ready_o=0. Raise ready_i → ready_o=1 next cycle.
- Flush at t+10 of a DIV → IDLE next cycle, valid_o never asserts. A new MUL 3*4 issued immediately → 12.
- Reset mid-DIV (rst_ni=0 for 1 cycle) → all outputs at reset values next cycle. MUL_FAST=0: MULSU -1 * 2 → high word 0xFFFFFFFF, valid_o at t+32.

Source files
------------

// File: rtl/milano_pkg.sv
// Shared types and decode helpers for the Milano multiply/divide unit.
package milano_pkg;

  localparam int unsigned MD_OP_W = 4;

  typedef enum logic [MD_OP_W-1:0] {
    MD_OP_NONE  = 4'd0,
    MD_OP_MUL   = 4'd1,
    MD_OP_MULH  = 4'd2,
    MD_OP_MULSU = 4'd3,
    MD_OP_MULU  = 4'd4,
    MD_OP_DIV   = 4'd5,
    MD_OP_DIVU  = 4'd6,
    MD_OP_REM   = 4'd7,
    MD_OP_REMU  = 4'd8
  } md_opt_e;

  typedef enum logic [2:0] {
    MDU_IDLE = 3'd0,
    MDU_MUL  = 3'd1,
    MDU_DIV  = 3'd2,
    MDU_FIX  = 3'd3,
    MDU_DONE = 3'd4
  } mdu_state_e;

  // rs1 is interpreted as two's complement
  function automatic logic md_is_signed_a(md_opt_e op);
    return op inside {MD_OP_MULH, MD_OP_MULSU, MD_OP_DIV, MD_OP_REM};
  endfunction

  // rs2 is interpreted as two's complement
  function automatic logic md_is_signed_b(md_opt_e op);
    return op inside {MD_OP_MULH, MD_OP_DIV, MD_OP_REM};
  endfunction

  function automatic logic md_is_mul(md_opt_e op);
    return op inside {MD_OP_MUL, MD_OP_MULH, MD_OP_MULSU, MD_OP_MULU};
  endfunction

  function automatic logic md_is_div(md_opt_e op);
    return op inside {MD_OP_DIV, MD_OP_DIVU, MD_OP_REM, MD_OP_REMU};
  endfunction

  function automatic logic md_is_rem(md_opt_e op);
    return op inside {MD_OP_REM, MD_OP_REMU};
  endfunction

endpackage

// File: rtl/milano_div_step.sv
// Combinational restoring-divide step retiring DIV_BITS quotient bits.
module milano_div_step #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned DIV_BITS = 1
) (
  input  logic [XLEN-1:0]     rem_i,
  input  logic [DIV_BITS-1:0] dvd_i,
  input  logic [XLEN-1:0]     divisor_i,
  output logic [XLEN-1:0]     rem_o,
  output logic [DIV_BITS-1:0] quo_o
);

  logic [XLEN:0] part;

  // Shift in one dividend bit per sub-step, subtract when it fits
  always_comb begin
    part  = {1'b0, rem_i};
    quo_o = '0;
    for (int i = int'(DIV_BITS) - 1; i >= 0; i--) begin
      part = {part[XLEN-1:0], dvd_i[i]};
      if (part >= {1'b0, divisor_i}) begin
        part     = part - {1'b0, divisor_i};
        quo_o[i] = 1'b1;
      end
    end
    rem_o = part[XLEN-1:0];
  end

endmodule

// File: rtl/milano_mdu.sv
// Multi-cycle multiply/divide unit with valid/ready handshake and flush.
module milano_mdu
  import milano_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MUL_FAST = 1,
  parameter int unsigned DIV_BITS = 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic [MD_OP_W-1:0]  md_op_i,
  input  logic [XLEN-1:0]     op_a_i,
  input  logic [XLEN-1:0]     op_b_i,
  input  logic                flush_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [XLEN-1:0]     result_o,
  output logic                busy_o
);

  localparam int unsigned DIV_STEPS = XLEN / DIV_BITS;
  localparam int unsigned CNT_W     = $clog2(XLEN + 1);
  localparam int unsigned MW        = 2 * XLEN;
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e        state_q, state_d;
  md_opt_e           op_q, op_d, op_in;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [MW-1:0]     acc_q, acc_d;     // {hi/remainder, lo/multiplier/quotient}
  logic [XLEN-1:0]   opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;
  logic [XLEN-1:0]   result_d;

  logic              accept, in_idle, is_mul_in, is_div_in, is_rem_in;
  logic              na_in, nb_in, div_zero, div_ovf;
  logic [XLEN-1:0]   mag_a_in, mag_b_in;
  logic [XLEN-1:0]   hi_cur, lo_cur, opnd_cur;
  logic [XLEN:0]     mul_sum;
  logic [MW-1:0]     mul_step, mul_fin, fast_prod, div_next;
  logic signed [XLEN:0] ext_a, ext_b;
  logic [XLEN-1:0]   div_rem;
  logic [DIV_BITS-1:0] div_quo;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  // Request decode, operand magnitudes and early-out detection
  always_comb begin
    op_in     = md_opt_e'(md_op_i);
    in_idle   = (state_q == MDU_IDLE);
    is_mul_in = md_is_mul(op_in);
    is_div_in = md_is_div(op_in);
    is_rem_in = md_is_rem(op_in);
    accept    = valid_i && in_idle && !flush_i && (is_mul_in || is_div_in);
    na_in     = md_is_signed_a(op_in) && op_a_i[XLEN-1];
    nb_in     = md_is_signed_b(op_in) && op_b_i[XLEN-1];
    mag_a_in  = na_in ? -op_a_i : op_a_i;
    mag_b_in  = nb_in ? -op_b_i : op_b_i;
    div_zero  = (op_b_i == '0);
    div_ovf   = md_is_signed_a(op_in) && (op_a_i == MIN_INT) && (op_b_i == '1);
  end

  // Datapath: the accept edge already performs the first iterative step
  always_comb begin
    hi_cur   = in_idle ? '0 : acc_q[MW-1:XLEN];
    lo_cur   = in_idle ? (is_mul_in ? mag_b_in : mag_a_in) : acc_q[XLEN-1:0];
    opnd_cur = in_idle ? (is_mul_in ? mag_a_in : mag_b_in) : opnd_q;

    mul_sum  = lo_cur[0] ? ({1'b0, hi_cur} + {1'b0, opnd_cur}) : {1'b0, hi_cur};
    mul_step = {mul_sum, lo_cur[XLEN-1:1]};
    mul_fin  = qneg_q ? -mul_step : mul_step;

    ext_a     = {na_in, op_a_i};
    ext_b     = {nb_in, op_b_i};
    fast_prod = MW'(ext_a) * MW'(ext_b);

    div_next = {div_rem, lo_cur[XLEN-DIV_BITS-1:0], div_quo};
    quo_fix  = qneg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix  = rneg_q ? -acc_q[MW-1:XLEN] : acc_q[MW-1:XLEN];
  end

  milano_div_step #(
    .XLEN     (XLEN),
    .DIV_BITS (DIV_BITS)
  ) u_div_step (
    .rem_i     (hi_cur),
    .dvd_i     (lo_cur[XLEN-1 -: DIV_BITS]),
    .divisor_i (opnd_cur),
    .rem_o     (div_rem),
    .quo_o     (div_quo)
  );

  // Next-state and register updates
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_o;

    unique case (state_q)
      MDU_IDLE: begin
        if (accept) begin
          op_d   = op_in;
          qneg_d = na_in ^ nb_in;
          rneg_d = na_in;
          cnt_d  = CNT_W'(1);
          if (is_mul_in) begin
            if (MUL_FAST != 0) begin
              result_d = (op_in == MD_OP_MUL) ? fast_prod[XLEN-1:0] : fast_prod[MW-1:XLEN];
              state_d  = MDU_DONE;
            end else begin
              acc_d   = mul_step;
              opnd_d  = opnd_cur;
              state_d = MDU_MUL;
            end
          end else if (div_zero) begin
            result_d = is_rem_in ? op_a_i : '1;
            state_d  = MDU_DONE;
          end else if (div_ovf) begin
            result_d = is_rem_in ? '0 : MIN_INT;
            state_d  = MDU_DONE;
          end else begin
            acc_d   = div_next;
            opnd_d  = opnd_cur;
            state_d = MDU_DIV;
          end
        end
      end
      MDU_MUL: begin
        acc_d = mul_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(XLEN - 1)) begin
          result_d = (op_q == MD_OP_MUL) ? mul_fin[XLEN-1:0] : mul_fin[MW-1:XLEN];
          state_d  = MDU_DONE;
        end
      end
      MDU_DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DIV_STEPS - 1)) begin
          state_d = MDU_FIX;
        end
      end
      MDU_FIX: begin
        result_d = md_is_rem(op_q) ? rem_fix : quo_fix;
        state_d  = MDU_DONE;
      end
      MDU_DONE: begin
        if (ready_i) begin
          state_d = MDU_IDLE;
        end
      end
      default: state_d = MDU_IDLE;
    endcase

    if (flush_i && !in_idle) begin
      state_d = MDU_IDLE;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= MDU_IDLE;
      op_q     <= MD_OP_NONE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b1;
      valid_o  <= 1'b0;
      busy_o   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_o <= result_d;
      ready_o  <= (state_d == MDU_IDLE);
      valid_o  <= (state_d == MDU_DONE);
      busy_o   <= (state_d != MDU_IDLE);
    end
  end

endmodule

// File: tb/tb_milano_mdu.sv
// Bench for milano_mdu: a fast/radix-2 and an iterative/radix-16 instance run in lockstep.
module tb_milano_mdu;
  import milano_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        valid_i;
  logic [3:0]  md_op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        ready_i;
  logic        rdy [2];
  logic        vo  [2];
  logic        bsy [2];
  logic [31:0] res [2];

  int n_chk  = 0;
  int n_pass = 0;

  logic [3:0]  r_op;
  logic [31:0] r_a, r_b;
  bit          seen;

  milano_mdu #(.XLEN(32), .MUL_FAST(1), .DIV_BITS(1)) dut_fast (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(rdy[0]),
    .md_op_i(md_op), .op_a_i(op_a), .op_b_i(op_b), .flush_i(flush),
    .valid_o(vo[0]), .ready_i(ready_i), .result_o(res[0]), .busy_o(bsy[0])
  );

  milano_mdu #(.XLEN(32), .MUL_FAST(0), .DIV_BITS(4)) dut_iter (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(rdy[1]),
    .md_op_i(md_op), .op_a_i(op_a), .op_b_i(op_b), .flush_i(flush),
    .valid_o(vo[1]), .ready_i(ready_i), .result_o(res[1]), .busy_o(bsy[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // RISC-V M-extension results from plain 64-bit arithmetic
  function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    case (op)
      MD_OP_MUL:   begin p = 64'(sa * sb); return p[31:0];  end
      MD_OP_MULH:  begin p = 64'(sa * sb); return p[63:32]; end
      MD_OP_MULSU: begin p = 64'(sa * ub); return p[63:32]; end
      MD_OP_MULU:  begin p = 64'(ua * ub); return p[63:32]; end
      MD_OP_DIV: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(int'(a) / int'(b));
      end
      MD_OP_REM: begin
        if (b == 32'h0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(int'(a) % int'(b));
      end
      MD_OP_DIVU: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
      MD_OP_REMU: return (b == 32'h0) ? a : a % b;
      default:    return 32'h0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input int fast, input int dbits);
    if (op inside {MD_OP_MUL, MD_OP_MULH, MD_OP_MULSU, MD_OP_MULU}) return (fast != 0) ? 1 : 32;
    if (b == 32'h0) return 1;
    if ((op == MD_OP_DIV || op == MD_OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 32 / dbits + 1;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return 32'($urandom_range(0, 20));
      default: return $urandom();
    endcase
  endfunction

  task automatic check_idle(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_ready[%0d]", tag, d), rdy[d], 1'b1);
      chk($sformatf("%s_valid[%0d]", tag, d), vo[d], 1'b0);
      chk($sformatf("%s_busy[%0d]", tag, d), bsy[d], 1'b0);
    end
  endtask

  // Issue one request to both units, check latency, result, hold and handoff
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] exp;
    int          lat_exp [2];
    int          lat_got [2];
    bit          done [2];
    exp        = ref_result(op, a, b);
    lat_exp[0] = ref_lat(op, a, b, 1, 1);
    lat_exp[1] = ref_lat(op, a, b, 0, 4);
    lat_got[0] = 0;
    lat_got[1] = 0;
    done[0]    = 1'b0;
    done[1]    = 1'b0;
    @(negedge clk);
    valid_i = 1'b1; md_op = op; op_a = a; op_b = b; ready_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0; md_op = 4'($urandom_range(0, 15)); op_a = $urandom(); op_b = $urandom();
    for (int k = 1; k <= 40; k++) begin
      for (int d = 0; d < 2; d++) begin
        if (done[d]) begin
          chk($sformatf("hold_valid[%0d]", d), vo[d], 1'b1);
          chk($sformatf("hold_result[%0d]", d), res[d], exp);
          chk($sformatf("hold_ready[%0d]", d), rdy[d], 1'b0);
        end else if (vo[d]) begin
          done[d]    = 1'b1;
          lat_got[d] = k;
          chk($sformatf("result[%0d] op%0d %h,%h", d, op, a, b), res[d], exp);
        end
      end
      if (done[0] && done[1]) break;
      @(negedge clk);
    end
    for (int d = 0; d < 2; d++) chk($sformatf("latency[%0d] op%0d", d, op), lat_got[d], lat_exp[d]);
    repeat (hold) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("bp_valid[%0d]", d), vo[d], 1'b1);
        chk($sformatf("bp_result[%0d]", d), res[d], exp);
        chk($sformatf("bp_ready[%0d]", d), rdy[d], 1'b0);
      end
    end
    // A request presented on the handoff edge must not be taken
    ready_i = 1'b1; valid_i = 1'b1; md_op = MD_OP_MUL;
    @(posedge clk);
    @(negedge clk);
    ready_i = 1'b0; valid_i = 1'b0;
    check_idle("handoff");
  endtask

  // Start a DIV and return at the negedge after the accept edge
  task automatic start_div(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    valid_i = 1'b1; md_op = MD_OP_DIV; op_a = a; op_b = b;
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    for (int d = 0; d < 2; d++) chk($sformatf("div_started[%0d]", d), bsy[d], 1'b1);
  endtask

  task automatic expect_silent(input string tag);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (vo[0] || vo[1]) seen = 1'b1;
    end
    chk(tag, seen, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; valid_i = 1'b0; ready_i = 1'b0; flush = 1'b0;
    md_op = MD_OP_NONE; op_a = '0; op_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    for (int d = 0; d < 2; d++) chk($sformatf("reset_result[%0d]", d), res[d], 32'h0);
    rst_n = 1'b1;

    run_op(MD_OP_MULH,  32'h8000_0000, 32'h8000_0000, 0);
    run_op(MD_OP_MULU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(MD_OP_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(MD_OP_DIV,   32'hFFFF_FFF9, 32'd2, 5);
    run_op(MD_OP_REM,   32'hFFFF_FFF9, 32'd2, 0);
    run_op(MD_OP_DIVU,  32'd100, 32'd7, 0);
    run_op(MD_OP_REMU,  32'd100, 32'd7, 0);
    run_op(MD_OP_DIVU,  32'd5, 32'd0, 0);
    run_op(MD_OP_REM,   32'd5, 32'd0, 0);
    run_op(MD_OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(MD_OP_REM,   32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(MD_OP_MULSU, 32'hFFFF_FFFF, 32'd2, 5);

    // Flush and NONE requests while idle are not accepted
    @(negedge clk);
    valid_i = 1'b1; md_op = MD_OP_MUL; op_a = 32'd3; op_b = 32'd4; flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; md_op = MD_OP_NONE;
    check_idle("flush_accept");
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    check_idle("op_none");

    // Flush mid-divide (fast unit) and in DONE with ready_i high (iterative unit)
    start_div(32'd1000, 32'd3);
    repeat (8) @(negedge clk);
    flush = 1'b1; ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; ready_i = 1'b0;
    check_idle("flush");
    expect_silent("flush_no_result");
    run_op(MD_OP_MUL, 32'd3, 32'd4, 0);

    // Reset mid-divide
    start_div(32'd1000, 32'd3);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_idle("midreset");
    for (int d = 0; d < 2; d++) chk($sformatf("midreset_result[%0d]", d), res[d], 32'h0);
    expect_silent("midreset_no_result");
    run_op(MD_OP_DIVU, 32'd100, 32'd7, 0);

    for (int n = 0; n < 120; n++) begin
      r_op = 4'($urandom_range(1, 8));
      r_a  = pick_operand();
      r_b  = pick_operand();
      run_op(r_op, r_a, r_b, $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
